bit_block_arbiter: RTL and testbench
====================================

// Module: bit_block_arbiter
// PURPOSE
//  Shares one bit_block_counter among NUM_REQ requesters.
//  Round-robin arbitration picks a requester and latches its word.
//  The block issues that word to the counter as a one-cycle data_enb pulse.
//  It waits for the counter's valid (or a timeout), then returns block_cnt to the granted requester.
//  Sits between the requester ports and the single bit_block_counter instance.
// PARAMETERS
//  NUM_REQ  4   number of requesters, 2..8
//  DATA_W   32  data / block_cnt width, matches counter
//  TIMEOUT  16  max WAIT cycles for cnt_valid before error response, >=2
// PORTS
//  clk            in   1                 clock, rising edge
//  rst_n          in   1                 async active-low reset
//  req            in   NUM_REQ           per-requester request level
//  req_data       in   NUM_REQ*DATA_W    word i at [i*DATA_W +: DATA_W]
//  gnt            out  NUM_REQ           one-hot 1-cycle pulse: request accepted
//  rsp_valid      out  NUM_REQ           one-hot 1-cycle pulse: result for requester i
//  rsp_cnt        out  DATA_W            result, valid with rsp_valid
//  rsp_err        out  1                 timeout flag, valid with rsp_valid
//  busy           out  1                 high in any state except IDLE
//  cnt_data       out  DATA_W            to counter data
//  cnt_data_enb   out  1                 to counter data_enb
//  cnt_block_cnt  in   DATA_W            from counter block_cnt
//  cnt_valid      in   1                 from counter valid
// BEHAVIOUR
//  - All outputs registered; reset: state=IDLE, all outputs 0, timer 0, rr_ptr=NUM_REQ-1 (req0 highest priority first).
//  - FSM IDLE->ISSUE->WAIT->RESP->IDLE; one transaction in flight at a time.
//  - IDLE, req!=0:
//    - winner = first set bit searching from rr_ptr+1 upward, wrapping.
//    - latch winner index and req_data word; next state ISSUE.
//  - IDLE, req==0: stay.
//  - ISSUE (1 cycle): gnt[idx]=1, cnt_data_enb=1, cnt_data=latched word; ->WAIT, timer=0.
//  - WAIT:
//    - cnt_data holds the latched word, cnt_data_enb=0.
//    - cnt_valid=1: capture cnt_block_cnt, err=0, ->RESP.
//    - else timer++; timer==TIMEOUT-1 with no valid: rsp_cnt=0, err=1, ->RESP.
//    - cnt_valid on the last timeout cycle wins (err=0).
//  - RESP (1 cycle): rsp_valid[idx]=1 with rsp_cnt/rsp_err; rr_ptr=idx; ->IDLE.
//  - cnt_valid in IDLE/ISSUE/RESP is ignored (stale result, discarded).
//  - Requester rules:
//    - holds req and req_data until gnt.
//    - drops req the cycle after gnt unless it wants a new transaction.
//    - req still high in IDLE is a new request.
//  - Latency:
//    - req sampled in IDLE cycle 0; gnt/enb in cycle 1.
//    - earliest rsp_valid in cycle 3 (valid in cycle 2).
//    - next gnt earliest in cycle 5.
//  - Requester deasserting req before gnt: never granted, nothing issued.
//  - Reset mid-operation: immediate return to reset values.
//    - in-flight transaction dropped, no rsp_valid.
//    - counter is reset by the same rst_n.
//  - Fairness: a continuously requesting requester is granted within NUM_REQ transactions.
// TESTING
//  - Single req:
//    - stimulus: req=0001, word 32'hF244_FABC.
//    - required: gnt=0001 in cycle 1 with cnt_data_enb=1 and cnt_data=F244FABC.
//    - required: rsp_valid=0001 one cycle after cnt_valid, rsp_cnt=counter value, rsp_err=0.
//  - Simultaneous req=0101 after reset, each dropping req after its gnt:
//    - required grant order 0 then 2.
//    - required: second gnt exactly 2 cycles after first rsp_valid.
//  - Continuous req=1111 for 8 transactions -> gnt sequence 0,1,2,3,0,1,2,3.
//  - Counter never asserts valid, TIMEOUT=16:
//    - required: rsp_valid 16 WAIT cycles after ISSUE, rsp_err=1, rsp_cnt=0.
//    - required: next request is served normally.
//  - rst_n low during WAIT:
//    - required: all outputs 0 asynchronously, no rsp_valid.
//    - required: after release, req=0010 is granted first as idx1.
//  - cnt_valid pulsed while IDLE -> no rsp_valid, state stays IDLE, busy=0.

Source files
------------

// File: rtl/bit_block_arbiter.sv
// Round-robin front end that shares one bit_block_counter among NUM_REQ requesters:
// latches the winner's word, pulses it into the counter, waits for valid or timeout, returns the count.
module bit_block_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_cnt,
    output logic                      rsp_err,
    output logic                      busy,
    output logic [DATA_W-1:0]         cnt_data,
    output logic                      cnt_data_enb,
    input  logic [DATA_W-1:0]         cnt_block_cnt,
    input  logic                      cnt_valid
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state, state_d;
    logic [IDX_W-1:0]    idx, idx_d;
    logic [IDX_W-1:0]    rr_ptr, rr_ptr_d;
    logic [TMR_W-1:0]    timer, timer_d;
    logic [NUM_REQ-1:0]  gnt_d, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_cnt_d, cnt_data_d;
    logic                rsp_err_d, busy_d, cnt_data_enb_d;
    logic [IDX_W-1:0]    winner;
    logic [DATA_W-1:0]   words [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            words[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    // Scan offsets from farthest to nearest so the requester closest after rr_ptr wins.
    always_comb begin
        int               pos;
        logic [IDX_W-1:0] pos_idx;
        winner  = rr_ptr;
        pos     = 0;
        pos_idx = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            pos = int'(rr_ptr) + off;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            pos_idx = IDX_W'(pos);
            if (req[pos_idx]) winner = pos_idx;
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d        = state;
        idx_d          = idx;
        rr_ptr_d       = rr_ptr;
        timer_d        = timer;
        gnt_d          = '0;
        rsp_valid_d    = '0;
        cnt_data_enb_d = 1'b0;
        cnt_data_d     = cnt_data;
        rsp_cnt_d      = rsp_cnt;
        rsp_err_d      = rsp_err;
        unique case (state)
            IDLE: begin
                if (req != '0) begin
                    idx_d          = winner;
                    cnt_data_d     = words[winner];
                    gnt_d          = NUM_REQ'(1) << winner;
                    cnt_data_enb_d = 1'b1;
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_valid) begin
                    rsp_cnt_d   = cnt_block_cnt;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = NUM_REQ'(1) << idx;
                    state_d     = RESP;
                end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                    rsp_cnt_d   = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = NUM_REQ'(1) << idx;
                    state_d     = RESP;
                end else begin
                    timer_d = timer + TMR_W'(1);
                end
            end
            RESP: begin
                rr_ptr_d = idx;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // NOTE: state uses non-blocking assignments so every register samples the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            rr_ptr       <= IDX_W'(NUM_REQ - 1);
            timer        <= '0;
            gnt          <= '0;
            rsp_valid    <= '0;
            rsp_cnt      <= '0;
            rsp_err      <= 1'b0;
            busy         <= 1'b0;
            cnt_data     <= '0;
            cnt_data_enb <= 1'b0;
        end else begin
            state        <= state_d;
            idx          <= idx_d;
            rr_ptr       <= rr_ptr_d;
            timer        <= timer_d;
            gnt          <= gnt_d;
            rsp_valid    <= rsp_valid_d;
            rsp_cnt      <= rsp_cnt_d;
            rsp_err      <= rsp_err_d;
            busy         <= busy_d;
            cnt_data     <= cnt_data_d;
            cnt_data_enb <= cnt_data_enb_d;
        end
    end

endmodule

// File: tb/tb_bit_block_arbiter.sv
// Directed bench for bit_block_arbiter; the bench plays both the requesters and the counter.
module tb_bit_block_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_cnt;
    logic                      rsp_err;
    logic                      busy;
    logic [DATA_W-1:0]         cnt_data;
    logic                      cnt_data_enb;
    logic [DATA_W-1:0]         cnt_block_cnt;
    logic                      cnt_valid;

    int checks = 0;
    int errors = 0;

    bit_block_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_cnt(rsp_cnt), .rsp_err(rsp_err),
        .busy(busy), .cnt_data(cnt_data), .cnt_data_enb(cnt_data_enb),
        .cnt_block_cnt(cnt_block_cnt), .cnt_valid(cnt_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = '0;
        cnt_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One complete transaction: wait for gnt, play the counter, check the response.
    task automatic serve(input string tag, input logic [NUM_REQ-1:0] exp_gnt, input logic drop,
                         input int delay, input logic [DATA_W-1:0] result, output int gap);
        logic [DATA_W-1:0] exp_word;
        exp_word = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (exp_gnt[i]) exp_word = req_data[i*DATA_W +: DATA_W];
        gap = 0;
        do begin
            tick();
            gap++;
        end while (gnt == '0 && gap < 20);
        check({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
        check({tag, "_enb"}, 32'(cnt_data_enb), 32'd1);
        check({tag, "_data"}, cnt_data, exp_word);
        if (drop) req = req & ~exp_gnt;
        tick();
        check({tag, "_wait_gnt"}, 32'(gnt), 32'd0);
        check({tag, "_wait_enb"}, 32'(cnt_data_enb), 32'd0);
        repeat (delay) tick();
        cnt_block_cnt = result;
        cnt_valid     = 1'b1;
        tick();
        cnt_valid = 1'b0;
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(exp_gnt));
        check({tag, "_rsp_cnt"}, rsp_cnt, result);
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    endtask

    initial begin
        int gap;
        int wait_cnt;
        req_data      = {32'h1234_5678, 32'hA5A5_0002, 32'h0000_1111, 32'hF244_FABC};
        cnt_block_cnt = '0;
        do_reset();

        // Reset values.
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_enb", 32'(cnt_data_enb), 32'd0);
        check("rst_cnt_data", cnt_data, 32'd0);
        check("rst_rsp_cnt", rsp_cnt, 32'd0);

        // Single requester.
        req = 4'b0001;
        serve("single", 4'b0001, 1'b1, 0, 32'd7, gap);
        check("single_gap", gap, 32'd1);
        tick();
        check("single_idle_busy", 32'(busy), 32'd0);
        check("single_idle_rsp", 32'(rsp_valid), 32'd0);

        // Two simultaneous requesters after reset.
        do_reset();
        req = 4'b0101;
        serve("pair0", 4'b0001, 1'b1, 1, 32'h0000_0033, gap);
        serve("pair2", 4'b0100, 1'b1, 0, 32'h0000_0044, gap);
        check("pair_gap", gap, 32'd2);

        // Everyone requesting continuously rotates 0,1,2,3,0,1,2,3.
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            serve($sformatf("rr%0d", i), NUM_REQ'(1) << (i % NUM_REQ), 1'b0, i % 3, 32'(100 + i), gap);
            if (i > 0) check($sformatf("rr%0d_gap", i), gap, 32'd2);
        end
        req = '0;

        // Counter never answers: error response after TIMEOUT wait cycles.
        cnt_block_cnt = 32'hDEAD_BEEF;
        req = 4'b0100;
        wait_cnt = 0;
        do begin
            tick();
            wait_cnt++;
        end while (gnt == '0 && wait_cnt < 20);
        check("to_gnt", 32'(gnt), 32'b0100);
        req = '0;
        wait_cnt = 0;
        do begin
            tick();
            wait_cnt++;
            if (wait_cnt == 8) check("to_busy", 32'(busy), 32'd1);
        end while (rsp_valid == '0 && wait_cnt < 40);
        check("to_latency", wait_cnt, 32'(TIMEOUT + 1));
        check("to_rsp_valid", 32'(rsp_valid), 32'b0100);
        check("to_rsp_err", 32'(rsp_err), 32'd1);
        check("to_rsp_cnt", rsp_cnt, 32'd0);

        // Normal service afterwards, then a valid on the last timeout cycle.
        req = 4'b0001;
        serve("after_to", 4'b0001, 1'b1, 3, 32'h0000_1234, gap);
        req = 4'b0010;
        serve("last_cycle", 4'b0010, 1'b1, TIMEOUT - 1, 32'h0000_0ABC, gap);

        // Reset asserted during WAIT.
        tick();
        req = 4'b0001;
        wait_cnt = 0;
        do begin
            tick();
            wait_cnt++;
        end while (gnt == '0 && wait_cnt < 20);
        check("rstw_gnt", 32'(gnt), 32'b0001);
        req = '0;
        tick();
        check("rstw_busy_before", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rstw_busy", 32'(busy), 32'd0);
        check("rstw_cnt_data", cnt_data, 32'd0);
        check("rstw_rsp_cnt", rsp_cnt, 32'd0);
        check("rstw_err", 32'(rsp_err), 32'd0);
        cnt_valid = 1'b1;
        tick();
        tick();
        check("rstw_no_rsp", 32'(rsp_valid), 32'd0);
        cnt_valid = 1'b0;
        rst_n = 1'b1;
        req = 4'b0010;
        serve("rstw_after", 4'b0010, 1'b1, 0, 32'h0000_0055, gap);

        // Stale cnt_valid while IDLE.
        tick();
        cnt_block_cnt = 32'h0000_0099;
        cnt_valid     = 1'b1;
        tick();
        cnt_valid = 1'b0;
        check("stale_rsp", 32'(rsp_valid), 32'd0);
        check("stale_busy", 32'(busy), 32'd0);
        tick();
        check("stale_rsp2", 32'(rsp_valid), 32'd0);
        check("stale_gnt2", 32'(gnt), 32'd0);
        check("stale_busy2", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
